ext_mem_ws: RTL and testbench



---
 rtl/ext_mem_pkg.sv | 25 ++
 rtl/ext_mem_array.sv | 38 +++
 rtl/ext_mem_ws.sv | 144 ++++++++++++++
 tb/tb_ext_mem_ws.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ext_mem_pkg.sv
// Shared types and sizing helpers for the wait-state external data memory.
package ext_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int LAT_MAX = 15;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int idx_w_of(input int depth_words);
    return $clog2(depth_words);
  endfunction

  function automatic int off_w_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/ext_mem_array.sv
// Single-port byte-enable RAM with registered read.
module ext_mem_array
  import ext_mem_pkg::*;
#(
  parameter int    DATA_W      = 32,
  parameter int    DEPTH_WORDS = 4096,
  parameter string INIT_FILE   = ""
) (
  input  logic                          clk_i,
  input  logic                          en_i,
  input  logic                          we_i,
  input  logic [bytes_of(DATA_W)-1:0]   be_i,
  input  logic [idx_w_of(DEPTH_WORDS)-1:0] idx_i,
  input  logic [DATA_W-1:0]             wdata_i,
  output logic [DATA_W-1:0]             rdata_o
);

  localparam int BYTES = bytes_of(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Reads and writes are exclusive per access, so a write leaves rdata_q untouched.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < BYTES; b++) begin
          if (be_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ext_mem_ws.sv
// Data-memory front end: request/ready handshake, programmable wait states,
// address range check and the response registers around ext_mem_array.
module ext_mem_ws
  import ext_mem_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter string       INIT_FILE   = ""
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mem_req_i,
  input  logic                  write_enable_i,
  input  logic [DATA_W/8-1:0]   byte_enable_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_W-1:0]     write_data_i,
  output logic [DATA_W-1:0]     read_data_o,
  output logic                  ready_o,
  output logic                  err_o
);

  localparam int BYTES = bytes_of(DATA_W);
  localparam int IDX_W = idx_w_of(DEPTH_WORDS);
  localparam int OFF_W = off_w_of(DATA_W);

  if (LATENCY < 0 || LATENCY > LAT_MAX) begin : g_bad_latency
    $error("ext_mem_ws: LATENCY must be within 0..15");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               rdv_q, rdv_d;

  logic               we_q, inr_q;
  logic [BYTES-1:0]   be_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  wdata_q;

  logic [31:0]        word_full;
  logic               in_range, accept, fire;
  logic               p_we, p_inr;
  logic [BYTES-1:0]   p_be;
  logic [IDX_W-1:0]   p_idx;
  logic [DATA_W-1:0]  p_wd, ram_rdata;

  // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
  assign word_full = (addr_i - BASE_ADDR) >> OFF_W;
  assign in_range  = word_full < 32'(DEPTH_WORDS);
  assign accept    = mem_req_i && (state_q == IDLE || state_q == RESP);

  // With no wait states the array must see the live request on the accept edge.
  always_comb begin
    p_we  = we_q;
    p_be  = be_q;
    p_idx = idx_q;
    p_inr = inr_q;
    p_wd  = wdata_q;
    fire  = (state_q == WAIT) && (cnt_q == '0);
    if (LATENCY == 0) begin
      p_we  = write_enable_i;
      p_be  = byte_enable_i;
      p_idx = word_full[IDX_W-1:0];
      p_inr = in_range;
      p_wd  = write_data_i;
      fire  = accept;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdv_d   = rdv_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (mem_req_i) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (fire) begin
      err_d = !p_inr;
      if (!p_we) rdv_d = p_inr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdv_q   <= rdv_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= write_enable_i;
      be_q    <= byte_enable_i;
      idx_q   <= word_full[IDX_W-1:0];
      inr_q   <= in_range;
      wdata_q <= write_data_i;
    end
  end

  ext_mem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (fire && p_inr),
    .we_i    (p_we),
    .be_i    (p_be),
    .idx_i   (p_idx),
    .wdata_i (p_wd),
    .rdata_o (ram_rdata)
  );

  // rdv_q masks the unreset RAM read register and zeroes out-of-range reads.
  assign read_data_o = rdv_q ? ram_rdata : '0;
  assign ready_o     = (state_q == RESP);
  assign err_o       = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_ext_mem_ws.sv
// Randomised and directed checks of ext_mem_ws against a word-array reference model.
module tb_ext_mem_ws;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_req, a_we, a_rdy, a_err;
  logic [3:0]  a_be;
  logic [31:0] a_addr, a_wd, a_rd;
  logic        b_rst_n, b_req, b_we, b_rdy, b_err;
  logic [3:0]  b_be;
  logic [31:0] b_addr, b_wd, b_rd;

  ext_mem_ws #(.DATA_W(32), .DEPTH_WORDS(4096), .LATENCY(0), .BASE_ADDR(32'h1000), .INIT_FILE("")) u_a (
    .clk_i(clk), .rst_ni(a_rst_n), .mem_req_i(a_req), .write_enable_i(a_we),
    .byte_enable_i(a_be), .addr_i(a_addr), .write_data_i(a_wd),
    .read_data_o(a_rd), .ready_o(a_rdy), .err_o(a_err));

  ext_mem_ws #(.DATA_W(32), .DEPTH_WORDS(4096), .LATENCY(3), .BASE_ADDR(32'h0), .INIT_FILE("")) u_b (
    .clk_i(clk), .rst_ni(b_rst_n), .mem_req_i(b_req), .write_enable_i(b_we),
    .byte_enable_i(b_be), .addr_i(b_addr), .write_data_i(b_wd),
    .read_data_o(b_rd), .ready_o(b_rdy), .err_o(b_err));

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ma [int];
  logic [31:0] mb [int];
  logic [31:0] a_last = 32'h0;
  logic [31:0] b_last = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic bit word_of(input logic [31:0] addr, input logic [31:0] base, output int idx);
    logic [31:0] off;
    off = addr - base;
    idx = int'(off / 4);
    return (off / 4) < 4096;
  endfunction

  // Zero-latency port: drive at a falling edge, response visible one cycle later.
  task automatic a_cycle(input bit req, input bit we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wd, input string tag);
    int idx;
    bit ok;
    bit exp_err;
    a_req = req; a_we = we; a_be = be; a_addr = addr; a_wd = wd;
    exp_err = 1'b0;
    if (req) begin
      ok = word_of(addr, 32'h1000, idx);
      exp_err = !ok;
      if (we) begin
        if (ok) ma[idx] = merge(ma.exists(idx) ? ma[idx] : 32'h0, wd, be);
      end else begin
        a_last = ok ? ma[idx] : 32'h0;
      end
    end
    @(negedge clk);
    chk({tag, ".rdy"}, 32'(a_rdy), 32'(req));
    chk({tag, ".err"}, 32'(a_err), 32'(exp_err));
    chk({tag, ".data"}, a_rd, a_last);
  endtask

  // Three-cycle-latency port: one real request, optional write pulses while waiting.
  task automatic b_txn(input bit we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, input bit pulse, input string tag);
    int idx;
    int first;
    int cnt;
    bit ok;
    ok = word_of(addr, 32'h0, idx);
    if (we) begin
      if (ok) mb[idx] = merge(mb.exists(idx) ? mb[idx] : 32'h0, wd, be);
    end else begin
      b_last = ok ? mb[idx] : 32'h0;
    end
    b_req = 1'b1; b_we = we; b_be = be; b_addr = addr; b_wd = wd;
    first = 0;
    cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (b_rdy) begin
        cnt++;
        if (first == 0) first = k;
        chk({tag, ".err"}, 32'(b_err), 32'(!ok));
        chk({tag, ".data"}, b_rd, b_last);
      end
      b_req = pulse && (k <= 3);
      b_we = 1'b1; b_be = 4'hF; b_addr = addr; b_wd = ~wd;
    end
    b_req = 1'b0;
    chk({tag, ".lat"}, 32'(first), 32'd4);
    chk({tag, ".npulse"}, 32'(cnt), 32'd1);
  endtask

  initial begin
    a_rst_n = 1'b0; a_req = 1'b0; a_we = 1'b0; a_be = 4'h0; a_addr = 32'h0; a_wd = 32'h0;
    b_rst_n = 1'b0; b_req = 1'b0; b_we = 1'b0; b_be = 4'h0; b_addr = 32'h0; b_wd = 32'h0;
    repeat (3) @(negedge clk);
    chk("a_reset.rdy", 32'(a_rdy), 32'd0);
    chk("a_reset.err", 32'(a_err), 32'd0);
    chk("a_reset.data", a_rd, 32'h0);
    chk("b_reset.rdy", 32'(b_rdy), 32'd0);
    chk("b_reset.data", b_rd, 32'h0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) a_cycle(1, 1, 4'hF, 32'h1000 + 4 * i, $urandom, "a_fill");
    a_cycle(1, 1, 4'hF, 32'h4FFC, 32'hCAFEF00D, "a_fill_top");
    a_cycle(1, 1, 4'hF, 32'h1010, 32'h0, "a_zero");
    a_cycle(1, 1, 4'b0101, 32'h1010, 32'h11223344, "a_be_wr");
    a_cycle(1, 0, 4'h0, 32'h1010, 32'h0, "a_raw");
    chk("a_raw.value", a_rd, 32'h00220044);
    a_cycle(1, 0, 4'h0, 32'h5000, 32'h0, "a_oor_rd");
    a_cycle(1, 1, 4'hF, 32'h0FFC, 32'h12345678, "a_oor_wr");
    a_cycle(1, 0, 4'h0, 32'h4FFC, 32'h0, "a_top_rd");
    a_cycle(1, 1, 4'h0, 32'h1014, 32'hFFFFFFFF, "a_be0_wr");
    a_cycle(1, 0, 4'h0, 32'h1016, 32'h0, "a_be0_rd");
    a_cycle(0, 0, 4'h0, 32'h0, 32'h0, "a_idle");

    for (int n = 0; n < 1000; n++) begin
      logic [31:0] addr;
      if ($urandom_range(0, 9) == 0)
        addr = ($urandom_range(0, 1) == 1) ? 32'h5000 + 4 * $urandom_range(0, 1000)
                                            : 32'h0FFC - 4 * $urandom_range(0, 1000);
      else
        addr = 32'h1000 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      a_cycle(1, 1'($urandom), 4'($urandom), addr, $urandom, "a_rand");
    end
    a_cycle(0, 0, 4'h0, 32'h0, 32'h0, "a_drain");

    b_txn(1, 4'hF, 32'h0, 32'hDEADBEEF, 0, "b_wr0");
    b_txn(0, 4'h0, 32'h0, 32'h0, 1, "b_rd0");
    chk("b_rd0.value", b_rd, 32'hDEADBEEF);
    b_txn(1, 4'hF, 32'h40, 32'hA5A5A5A5, 1, "b_wr40");
    b_txn(0, 4'h0, 32'h40, 32'h0, 0, "b_rd40");
    b_txn(0, 4'h0, 32'h4000, 32'h0, 0, "b_oor");
    b_txn(0, 4'h0, 32'h40, 32'h0, 0, "b_rd40b");

    b_req = 1'b1; b_we = 1'b1; b_be = 4'hF; b_addr = 32'h40; b_wd = 32'h5A5A5A5A;
    @(negedge clk);
    b_req = 1'b0;
    @(negedge clk);
    b_rst_n = 1'b0;
    #1;
    chk("b_midrst.rdy", 32'(b_rdy), 32'd0);
    chk("b_midrst.err", 32'(b_err), 32'd0);
    chk("b_midrst.data", b_rd, 32'h0);
    b_last = 32'h0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("b_midrst.quiet", 32'(b_rdy), 32'd0);
      if (k == 1) b_rst_n = 1'b1;
    end
    b_txn(0, 4'h0, 32'h40, 32'h0, 0, "b_after_rst");
    chk("b_after_rst.value", b_rd, 32'hA5A5A5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
